serial_word_capture: RTL and testbench

- Downstream consumer of the three-input register pipeline's single-bit `out` stream.
- Discards the pipeline fill bits after reset, then packs the valid bit stream LSB-first into WIDTH-bit words.
- Presents each word through a one-entry output buffer with a valid/ready handshake and a sticky overflow flag.
- Serves as the capture point that turns the serial timing-example output into observable words for the path-analysis benches.

---
 rtl/swc_pkg.sv | 12 +
 rtl/swc_out_buffer.sv | 66 ++++++
 rtl/serial_word_capture.sv | 111 +++++++++++
 tb/tb_serial_word_capture.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/swc_pkg.sv
// Shared types and constants for serial_word_capture and its output buffer.
package swc_pkg;

  typedef enum logic {
    FLUSH = 1'b0,
    SHIFT = 1'b1
  } swc_state_t;

  localparam int SWC_MAX_WIDTH    = 32;
  localparam int SWC_DEFAULT_SKIP = 5;

endpackage

// File: rtl/swc_out_buffer.sv
// One-entry output register with valid/ready handshake and sticky overflow.
// Optional registered even-parity output when SWC_PARITY_EN is defined.
module swc_out_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_word,
  input  logic             ready,
  output logic [WIDTH-1:0] word,
  output logic             valid,
  output logic             overflow
`ifdef SWC_PARITY_EN
  ,
  output logic             parity
`endif
);

  logic [WIDTH-1:0] word_reg;
  logic             valid_reg;
  logic             overflow_reg;
  logic             drain;
  logic             accept;

  assign drain  = valid_reg & ready;
  // A completing word can take the slot if it is empty or emptying this cycle.
  assign accept = load & (~valid_reg | drain);

  always_ff @(posedge clk) begin
    if (rst) begin
      word_reg     <= '0;
      valid_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (accept) begin
        word_reg  <= load_word;
        valid_reg <= 1'b1;
      end else if (drain) begin
        valid_reg <= 1'b0;
      end
      if (load & ~accept) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign word     = word_reg;
  assign valid    = valid_reg;
  assign overflow = overflow_reg;

`ifdef SWC_PARITY_EN
  logic parity_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_reg <= 1'b0;
    end else if (accept) begin
      parity_reg <= ^load_word;
    end
  end

  assign parity = parity_reg;
`endif

endmodule

// File: rtl/serial_word_capture.sv
// Discards SKIP fill bits after reset, then packs the serial stream LSB-first
// into WIDTH-bit words. Define SWC_PARITY_EN to add the out_parity output.
module serial_word_capture
  import swc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SKIP  = SWC_DEFAULT_SKIP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             flushing
`ifdef SWC_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  // SKIP=0 would give a zero-width counter; keep one bit that never moves.
  localparam int SKW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam int BCW = $clog2(WIDTH);
  localparam swc_state_t RESET_STATE = (SKIP > 0) ? FLUSH : SHIFT;
  localparam logic [SKW-1:0] SKIP_LAST = (SKIP > 0) ? SKW'(SKIP - 1) : '0;
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WIDTH - 1);

  swc_state_t       state_reg, state_next;
  logic [SKW-1:0]   skip_cnt_reg, skip_cnt_next;
  logic [BCW-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [WIDTH-1:0] bit_we;
  logic             shift_en;
  logic             word_done;

  always_comb begin
    state_next    = state_reg;
    skip_cnt_next = skip_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_en      = 1'b0;
    word_done     = 1'b0;
    case (state_reg)
      FLUSH: begin
        if (in_valid) begin
          if (skip_cnt_reg == SKIP_LAST) begin
            state_next    = SHIFT;
            skip_cnt_next = '0;
          end else begin
            skip_cnt_next = skip_cnt_reg + 1'b1;
          end
        end
      end
      SHIFT: begin
        if (in_valid) begin
          shift_en = 1'b1;
          if (bit_cnt_reg == BIT_LAST) begin
            bit_cnt_next = '0;
            word_done    = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = RESET_STATE;
    endcase
  end

  // Per-bit write enables; shreg_next already carries the current bit, so it
  // is the complete word on the completion cycle.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shreg
    assign bit_we[gi]     = shift_en && (bit_cnt_reg == BCW'(gi));
    assign shreg_next[gi] = bit_we[gi] ? in_bit : shreg_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RESET_STATE;
      skip_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shreg_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      skip_cnt_reg <= skip_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shreg_reg    <= shreg_next;
    end
  end

  assign flushing = (state_reg == FLUSH);

  swc_out_buffer #(
    .WIDTH(WIDTH)
  ) u_out_buffer (
    .clk      (clk),
    .rst      (rst),
    .load     (word_done),
    .load_word(shreg_next),
    .ready    (out_ready),
    .word     (out_word),
    .valid    (out_valid),
    .overflow (overflow)
`ifdef SWC_PARITY_EN
    ,
    .parity   (out_parity)
`endif
  );

endmodule

// File: tb/tb_serial_word_capture.sv
// Self-checking bench for serial_word_capture (WIDTH=8, SKIP=5) against a
// bit-count based reference model; parity checks when SWC_PARITY_EN is defined.
module tb_serial_word_capture;

  localparam int W = 8;
  localparam int S = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_bit = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] out_word;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         overflow;
  logic         flushing;
`ifdef SWC_PARITY_EN
  logic         out_parity;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model: count valid bits since reset, skip the first S,
  // place data bit d at position d%W, and keep a one-slot buffer.
  int           m_flushed;
  int           m_data_cnt;
  logic [W-1:0] m_acc;
  logic [W-1:0] m_word;
  logic         m_full;
  logic         m_ovf;

  always #5 clk = ~clk;

  serial_word_capture #(.WIDTH(W), .SKIP(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_bit   (in_bit),
    .in_valid (in_valid),
    .out_word (out_word),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow (overflow),
    .flushing (flushing)
`ifdef SWC_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  task automatic model_edge();
    bit drain;
    drain = m_full && out_ready;
    if (rst) begin
      m_flushed = 0; m_data_cnt = 0; m_acc = '0;
      m_word = '0; m_full = 1'b0; m_ovf = 1'b0;
    end else begin
      bit done;
      done = 1'b0;
      if (in_valid) begin
        if (m_flushed < S) m_flushed++;
        else begin
          m_acc[m_data_cnt % W] = in_bit;
          m_data_cnt++;
          done = (m_data_cnt % W) == 0;
        end
      end
      if (done) begin
        if (!m_full || drain) begin m_word = m_acc; m_full = 1'b1; end
        else m_ovf = 1'b1;
      end else if (drain) m_full = 1'b0;
    end
  endtask

  task automatic step(input bit v, input bit b, input bit r);
    in_valid = v; in_bit = b; out_ready = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit r, input bit gap);
    for (int i = 0; i < W; i++) begin
      step(1, w[i], r);
      if (gap) step(0, ~w[i], r);
    end
  endtask

  task automatic flush_bits(input bit gap);
    for (int i = 0; i < S; i++) begin
      step(1, 1'b1, 1'b0);
      if (gap) step(0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (out_valid !== 1'b0 || out_word !== 8'h00 || overflow !== 1'b0 || flushing !== 1'b1) begin
      miscompares++;
      $display("FAIL reset: valid=%b word=%h ovf=%b flushing=%b, required 0 00 0 1",
               out_valid, out_word, overflow, flushing);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] w;
    do_reset();
    flush_bits(0);
    w = 8'h4D;
    for (int i = 0; i < W - 1; i++) step(1, w[i], 1'b1);
    vectors++;
    if (out_valid !== 1'b0 || flushing !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_early: valid=%b flushing=%b, required 0 0", out_valid, flushing);
    end
    step(1, w[W-1], 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_word !== 8'h4D) begin
      miscompares++;
      $display("FAIL basic_word: valid=%b word=%h, required 1 4d", out_valid, out_word);
    end
    step(0, 0, 1'b1);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_drain: valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_gapped();
    do_reset();
    flush_bits(1);
    send_word(8'h4D, 1'b0, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_word !== 8'h4D || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL gapped_word: valid=%b word=%h ovf=%b, required 1 4d 0",
               out_valid, out_word, overflow);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    flush_bits(0);
    send_word(8'hA5, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b0);
    vectors++;
    if (overflow !== 1'b1 || out_word !== 8'hA5 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_16: ovf=%b word=%h valid=%b, required 1 a5 1",
               overflow, out_word, out_valid);
    end
    send_word(8'hFF, 1'b0, 1'b0);
    vectors++;
    if (out_word !== 8'hA5) begin
      miscompares++;
      $display("FAIL overflow_hold: word=%h, required a5", out_word);
    end
    step(0, 0, 1'b1);
    vectors++;
    if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_drain: valid=%b ovf=%b, required 0 1", out_valid, overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w;
    do_reset();
    flush_bits(0);
    send_word(8'h01, 1'b0, 1'b0);
    w = 8'h80;
    for (int i = 0; i < W - 1; i++) step(1, w[i], 1'b0);
    step(1, w[W-1], 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_word !== 8'h80 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_back: valid=%b word=%h ovf=%b, required 1 80 0",
               out_valid, out_word, overflow);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    flush_bits(0);
    send_word(8'h5A, 1'b0, 1'b0);
    send_word(8'hC3, 1'b0, 1'b0);
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
    do_reset();
    vectors++;
    if (out_valid !== 1'b0 || overflow !== 1'b0 || flushing !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid: valid=%b ovf=%b flushing=%b, required 0 0 1",
               out_valid, overflow, flushing);
    end
    for (int i = 0; i < S - 1; i++) step(1, 1'b0, 1'b0);
    vectors++;
    if (flushing !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_flush4: flushing=%b, required 1", flushing);
    end
    step(1, 1'b0, 1'b0);
    vectors++;
    if (flushing !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_flush5: flushing=%b, required 0", flushing);
    end
    send_word(8'h96, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_word !== 8'h96) begin
      miscompares++;
      $display("FAIL reset_mid_word: valid=%b word=%h, required 1 96", out_valid, out_word);
    end
  endtask

`ifdef SWC_PARITY_EN
  task automatic test_parity();
    do_reset();
    flush_bits(0);
    send_word(8'h07, 1'b1, 1'b0);
    vectors++;
    if (out_parity !== 1'b1) begin
      miscompares++;
      $display("FAIL parity_07: parity=%b, required 1", out_parity);
    end
    send_word(8'h03, 1'b1, 1'b0);
    vectors++;
    if (out_parity !== 1'b0) begin
      miscompares++;
      $display("FAIL parity_03: parity=%b, required 0", out_parity);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) == 0);
      rst = 1'b0;
      vectors++;
      if (out_valid !== m_full || overflow !== m_ovf || flushing !== (m_flushed < S) ||
          (m_full && out_word !== m_word)) begin
        miscompares++;
        $display("FAIL random cyc %0d: valid=%b word=%h ovf=%b flushing=%b, required %b %h %b %b",
                 c, out_valid, out_word, overflow, flushing, m_full, m_word, m_ovf, m_flushed < S);
      end
`ifdef SWC_PARITY_EN
      vectors++;
      if (m_full && out_parity !== ^m_word) begin
        miscompares++;
        $display("FAIL random_parity cyc %0d: parity=%b, required %b", c, out_parity, ^m_word);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
`ifdef SWC_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
